// File: rtl/hangman_word_entry.sv
// Front end for Game_logic: assembles the host's secret word, then filters player guesses.
// Define GUESS_DUP_FILTER_EN to enable repeated-guess suppression and the usedMask register.
//
// state   | meaning
// S_ENTRY | host typing the secret word; confirm with a full word starts the game
// S_PLAY  | word frozen; letters become guesses until game_done or clr
module hangman_word_entry #(
   parameter int WORD_LEN = 5,
   parameter int CHAR_W   = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [CHAR_W-1:0]            letter_in_i,
   input  logic                         letter_vld_i,
   input  logic                         back_i,
   input  logic                         clr_i,
   input  logic                         confirm_i,
   input  logic                         game_done_i,
   output logic [WORD_LEN*CHAR_W-1:0]   setWord_o,
   output logic                         toggle_state_o,
   output logic [CHAR_W-1:0]            guess_o,
   output logic                         guess_vld_o,
   output logic                         dup_guess_o,
   output logic                         bad_char_o,
   output logic [2:0]                   wordCount_o,
   output logic                         playing_o,
   output logic [25:0]                  usedMask_o
);

   typedef enum logic {S_ENTRY = 1'b0, S_PLAY = 1'b1} state_t;

   localparam logic [2:0]        FULL     = 3'(WORD_LEN);
   localparam logic [CHAR_W-1:0] UC_A     = CHAR_W'(8'h41);
   localparam logic [CHAR_W-1:0] UC_Z     = CHAR_W'(8'h5A);
   localparam logic [CHAR_W-1:0] LC_A     = CHAR_W'(8'h61);
   localparam logic [CHAR_W-1:0] LC_Z     = CHAR_W'(8'h7A);
   localparam logic [CHAR_W-1:0] CASE_OFS = CHAR_W'(8'h20);

   state_t                       state_q, state_d;
   logic [WORD_LEN*CHAR_W-1:0]   word_q, word_d;
   logic [2:0]                   count_q, count_d;
   logic [CHAR_W-1:0]            guess_q, guess_d;
   logic                         gv_q, gv_d;
   logic                         bad_q, bad_d;
   logic                         tog_q, tog_d;

   logic                         is_upper, is_lower, is_letter;
   logic [CHAR_W-1:0]            norm;
   logic [2:0]                   back_idx;

`ifdef GUESS_DUP_FILTER_EN
   logic [25:0]                  mask_q, mask_d;
   logic                         dup_q, dup_d;
   logic [4:0]                   letter_idx;
   logic [25:0]                  letter_bit;
   logic                         used_hit;
`endif

   always_comb begin
      is_upper  = (letter_in_i >= UC_A) && (letter_in_i <= UC_Z);
      is_lower  = (letter_in_i >= LC_A) && (letter_in_i <= LC_Z);
      is_letter = is_upper || is_lower;
      norm      = is_lower ? (letter_in_i - CASE_OFS) : letter_in_i;
      back_idx  = count_q - 3'd1;
`ifdef GUESS_DUP_FILTER_EN
      letter_idx = 5'(norm - UC_A);
      letter_bit = 26'(1) << letter_idx;
      used_hit   = |(mask_q & letter_bit);
`endif
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      count_d = count_q;
      guess_d = guess_q;
      gv_d    = 1'b0;
      bad_d   = 1'b0;
      tog_d   = 1'b0;
`ifdef GUESS_DUP_FILTER_EN
      mask_d  = mask_q;
      dup_d   = 1'b0;
`endif
      unique case (state_q)
         S_ENTRY: begin
            if (clr_i) begin
               word_d  = '0;
               count_d = '0;
            end else if (confirm_i) begin
               if (count_q == FULL) begin
                  tog_d   = 1'b1;
                  state_d = S_PLAY;
               end
            end else if (back_i) begin
               if (count_q != 3'd0) begin
                  count_d = back_idx;
                  for (int k = 0; k < WORD_LEN; k++)
                     if (back_idx == 3'(k)) word_d[(WORD_LEN-1-k)*CHAR_W +: CHAR_W] = '0;
               end
            end else if (letter_vld_i) begin
               if (!is_letter) begin
                  bad_d = 1'b1;
               end else if (count_q != FULL) begin
                  count_d = count_q + 3'd1;
                  for (int k = 0; k < WORD_LEN; k++)
                     if (count_q == 3'(k)) word_d[(WORD_LEN-1-k)*CHAR_W +: CHAR_W] = norm;
               end
            end
         end
         S_PLAY: begin
            // game_done outranks a coincident letter, so the last keypress of a finished game is dropped
            if (clr_i || game_done_i) begin
               state_d = S_ENTRY;
               word_d  = '0;
               count_d = '0;
               guess_d = '0;
`ifdef GUESS_DUP_FILTER_EN
               mask_d  = '0;
`endif
            end else if (confirm_i || back_i) begin
               state_d = S_PLAY;
            end else if (letter_vld_i) begin
               if (!is_letter) begin
                  bad_d = 1'b1;
`ifdef GUESS_DUP_FILTER_EN
               end else if (used_hit) begin
                  dup_d = 1'b1;
               end else begin
                  guess_d = norm;
                  gv_d    = 1'b1;
                  mask_d  = mask_q | letter_bit;
               end
`else
               end else begin
                  guess_d = norm;
                  gv_d    = 1'b1;
               end
`endif
            end
         end
         default: state_d = S_ENTRY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_ENTRY;
         word_q  <= '0;
         count_q <= '0;
         guess_q <= '0;
         gv_q    <= 1'b0;
         bad_q   <= 1'b0;
         tog_q   <= 1'b0;
`ifdef GUESS_DUP_FILTER_EN
         mask_q  <= '0;
         dup_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         count_q <= count_d;
         guess_q <= guess_d;
         gv_q    <= gv_d;
         bad_q   <= bad_d;
         tog_q   <= tog_d;
`ifdef GUESS_DUP_FILTER_EN
         mask_q  <= mask_d;
         dup_q   <= dup_d;
`endif
      end
   end

   assign setWord_o      = word_q;
   assign toggle_state_o = tog_q;
   assign guess_o        = guess_q;
   assign guess_vld_o    = gv_q;
   assign bad_char_o     = bad_q;
   assign wordCount_o    = count_q;
   assign playing_o      = (state_q == S_PLAY);
`ifdef GUESS_DUP_FILTER_EN
   assign dup_guess_o    = dup_q;
   assign usedMask_o     = mask_q;
`else
   assign dup_guess_o    = 1'b0;
   assign usedMask_o     = '0;
`endif

endmodule
